// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the framed UART transmitter.
// frame_bits() gives the frame length in baud ticks.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic int unsigned frame_bits(input int unsigned data_w,
                                               input logic        par_en,
                                               input logic        stop2);
        return 32'd1 + data_w + {31'd0, par_en} + 32'd1 + {31'd0, stop2};
    endfunction

endpackage

// File: rtl/uart_tx_frame_serializer_if.sv
// Word handshake and per-frame configuration between the TX data source
// and the frame serializer.
interface uart_tx_frame_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] P_Data;
    logic              Data_Valid;
    logic              Data_Ready;
    logic              Par_En;
    logic              Par_Typ;
    logic              Stop2;
    logic              Msb_First;

    modport master (
        output P_Data, Data_Valid, Par_En, Par_Typ, Stop2, Msb_First,
        input  Data_Ready
    );

    modport slave (
        input  P_Data, Data_Valid, Par_En, Par_Typ, Stop2, Msb_First,
        output Data_Ready
    );
endinterface

// File: rtl/uart_tx_shift_reg.sv
// Data shift register for the UART frame: loads a word with its direction
// and parity sense, shifts one bit per enabled baud tick.
module uart_tx_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic              msb_first,
    input  logic              par_typ,
    input  logic [DATA_W-1:0] data_in,
    output logic              cur_bit,
    output logic              nxt_bit,
    output logic              parity
);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic              msb_q, msb_d;
    logic              parity_q, parity_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        shift_d  = shift_q;
        msb_d    = msb_q;
        parity_d = parity_q;
        if (load) begin
            shift_d  = data_in;
            msb_d    = msb_first;
            parity_d = (^data_in) ^ par_typ;
        end else if (shift) begin
            shift_d = msb_q ? {shift_q[DATA_W-2:0], 1'b0} : {1'b0, shift_q[DATA_W-1:1]};
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q  <= '0;
            msb_q    <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            msb_q    <= msb_d;
            parity_q <= parity_d;
        end
    end

    // nxt_bit is the bit on the line after this edge, so the top can register it.
    assign cur_bit = msb_q ? shift_q[DATA_W-1] : shift_q[0];
    assign nxt_bit = shift ? (msb_q ? shift_q[DATA_W-2] : shift_q[1]) : cur_bit;
    assign parity  = parity_q;

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// Framed UART transmitter: start bit, DATA_W data bits, optional parity and
// one or two stop bits, paced by an external one-cycle baud tick.
module uart_tx_frame_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        Enable,
    uart_tx_frame_serializer_if.slave   tx,
    output logic                        Serial_Data,
    output logic                        Busy,
    output logic                        Done
);

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              par_en_q, par_en_d;
    logic              stop2_q, stop2_d;
    logic              serial_q, serial_d;
    logic              done_q, done_d;

    logic              accept;
    logic              sr_shift;
    logic              sr_cur_bit;
    logic              sr_nxt_bit;
    logic              sr_parity;

    assign accept   = tx.Data_Valid && (state_q == IDLE);
    assign sr_shift = (state_q == DATA) && Enable;

    uart_tx_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift_reg (
        .clk       (CLK),
        .rst       (RST),
        .load      (accept),
        .shift     (sr_shift),
        .msb_first (tx.Msb_First),
        .par_typ   (tx.Par_Typ),
        .data_in   (tx.P_Data),
        .cur_bit   (sr_cur_bit),
        .nxt_bit   (sr_nxt_bit),
        .parity    (sr_parity)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        par_en_d = par_en_q;
        stop2_d  = stop2_q;
        done_d   = 1'b0;
        serial_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = START;
                    cnt_d    = '0;
                    par_en_d = tx.Par_En;
                    stop2_d  = tx.Stop2;
                end
            end
            START: begin
                if (Enable) state_d = DATA;
            end
            DATA: begin
                if (Enable) begin
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = par_en_q ? PARITY : STOP1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (Enable) state_d = STOP1;
            end
            STOP1: begin
                if (Enable) begin
                    if (stop2_q) begin
                        state_d = STOP2;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (Enable) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line value is computed from the next state so the output flop is glitch-free.
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = sr_nxt_bit;
            PARITY:  serial_d = sr_parity;
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            par_en_q <= par_en_d;
            stop2_q  <= stop2_d;
            serial_q <= serial_d;
            done_q   <= done_d;
        end
    end

    assign tx.Data_Ready = (state_q == IDLE);
    assign Busy          = (state_q != IDLE);
    assign Serial_Data   = serial_q;
    assign Done          = done_q;

    logic unused_cur_bit;
    assign unused_cur_bit = sr_cur_bit;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Self-checking bench for uart_tx_frame_serializer at DATA_W=8 and DATA_W=5:
// table-driven frames, back-to-back transfer and mid-frame reset abort.
module tb_uart_tx_frame_serializer;
    import uart_tx_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic enable;

    always #5 clk = ~clk;

    uart_tx_frame_serializer_if #(.DATA_W(8)) if8 ();
    uart_tx_frame_serializer_if #(.DATA_W(5)) if5 ();

    logic ser8, busy8, done8;
    logic ser5, busy5, done5;

    uart_tx_frame_serializer #(.DATA_W(8)) dut8 (
        .CLK         (clk),
        .RST         (rst),
        .Enable      (enable),
        .tx          (if8),
        .Serial_Data (ser8),
        .Busy        (busy8),
        .Done        (done8)
    );

    uart_tx_frame_serializer #(.DATA_W(5)) dut5 (
        .CLK         (clk),
        .RST         (rst),
        .Enable      (enable),
        .tx          (if5),
        .Serial_Data (ser5),
        .Busy        (busy5),
        .Done        (done5)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_cnt8 = 0;
    int done_cnt5 = 0;
    int exp_done8 = 0;
    int exp_done5 = 0;
    logic exp_q[$];

    always @(negedge clk) begin
        if (done8 === 1'b1) done_cnt8++;
        if (done5 === 1'b1) done_cnt5++;
    end

    // line holds the frame in transmission order, first bit at [11].
    typedef struct {
        logic       sel5;
        logic [8:0] data;
        logic       par_en;
        logic       par_typ;
        logic       stop2;
        logic       msb;
        logic       en_acc;
        int         len;
        logic [11:0] line;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic s_line(input logic sel);
        return sel ? ser5 : ser8;
    endfunction
    function automatic logic s_busy(input logic sel);
        return sel ? busy5 : busy8;
    endfunction
    function automatic logic s_done(input logic sel);
        return sel ? done5 : done8;
    endfunction
    function automatic logic s_ready(input logic sel);
        return sel ? if5.Data_Ready : if8.Data_Ready;
    endfunction

    task automatic set_word(input logic sel, input logic [8:0] data, input logic par_en,
                            input logic par_typ, input logic stop2, input logic msb);
        if (sel) begin
            if5.P_Data = data[4:0]; if5.Par_En = par_en; if5.Par_Typ = par_typ;
            if5.Stop2 = stop2; if5.Msb_First = msb;
        end else begin
            if8.P_Data = data[7:0]; if8.Par_En = par_en; if8.Par_Typ = par_typ;
            if8.Stop2 = stop2; if8.Msb_First = msb;
        end
    endtask

    task automatic set_valid(input logic sel, input logic v);
        if (sel) if5.Data_Valid = v;
        else     if8.Data_Valid = v;
    endtask

    task automatic push_line(input logic [11:0] line, input int len);
        for (int i = 0; i < len; i++) exp_q.push_back(line[11-i]);
    endtask

    task automatic push_model(input logic [8:0] data, input int dw, input logic par_en,
                              input logic par_typ, input logic stop2, input logic msb);
        logic p;
        p = par_typ;
        exp_q.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            exp_q.push_back(msb ? data[dw-1-i] : data[i]);
            p = p ^ data[i];
        end
        if (par_en) exp_q.push_back(p);
        exp_q.push_back(1'b1);
        if (stop2) exp_q.push_back(1'b1);
    endtask

    task automatic accept(input logic sel, input logic en_acc, input logic hold);
        set_valid(sel, 1'b1);
        check("ready_before_accept", s_ready(sel), 1'b1);
        enable = en_acc;
        tick();
        enable = 1'b0;
        if (!hold) set_valid(sel, 1'b0);
        check("busy_after_accept", s_busy(sel), 1'b1);
        check("ready_after_accept", s_ready(sel), 1'b0);
    endtask

    // Enable every 4 cycles; each bit is sampled at its first and last cycle.
    task automatic run_frame(input logic sel, input int len);
        logic exp;
        for (int i = 0; i < len; i++) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL scoreboard_empty: no expected bit for bit %0d", i);
                exp = 1'b1;
            end else begin
                exp = exp_q.pop_front();
            end
            check($sformatf("bit%0d_start", i), s_line(sel), exp);
            check($sformatf("bit%0d_busy", i), s_busy(sel), 1'b1);
            repeat (3) tick();
            check($sformatf("bit%0d_end", i), s_line(sel), exp);
            enable = 1'b1;
            tick();
            enable = 1'b0;
        end
        check("done_at_frame_end", s_done(sel), 1'b1);
        check("busy_at_frame_end", s_busy(sel), 1'b0);
        check("ready_at_frame_end", s_ready(sel), 1'b1);
        check("idle_line_at_frame_end", s_line(sel), 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 9'h0A5, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, 10, 12'b010100101100};
        vecs[1] = '{1'b0, 9'h007, 1'b1, PAR_EVEN, 1'b0, 1'b0, 1'b0, 11, 12'b011100000110};
        vecs[2] = '{1'b0, 9'h007, 1'b1, PAR_ODD,  1'b0, 1'b0, 1'b0, 11, 12'b011100000010};
        vecs[3] = '{1'b1, 9'h013, 1'b0, PAR_EVEN, 1'b1, 1'b1, 1'b0,  8, 12'b010011110000};
        vecs[4] = '{1'b0, 9'h0C3, 1'b1, PAR_ODD,  1'b1, 1'b1, 1'b1, 12, 12'b011000011111};
        vecs[5] = '{1'b1, 9'h00D, 1'b1, PAR_EVEN, 1'b0, 1'b0, 1'b1,  8, 12'b010110110000};

        rst = 1'b1;
        enable = 1'b0;
        set_word(1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_word(1'b1, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_valid(1'b0, 1'b0);
        set_valid(1'b1, 1'b0);

        // Reset and idle
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            check("rst_line", s_line(s[0]), 1'b1);
            check("rst_busy", s_busy(s[0]), 1'b0);
            check("rst_ready", s_ready(s[0]), 1'b1);
            check("rst_done", s_done(s[0]), 1'b0);
        end
        rst = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            enable = 1'b1;
            tick();
            enable = 1'b0;
            check("idle_line", ser8, 1'b1);
            check("idle_busy", busy8, 1'b0);
            check("idle_ready", if8.Data_Ready, 1'b1);
            tick();
        end
        check("idle_no_done", done_cnt8 + done_cnt5, 0);

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            set_word(vecs[v].sel5, vecs[v].data, vecs[v].par_en, vecs[v].par_typ,
                     vecs[v].stop2, vecs[v].msb);
            push_line(vecs[v].line, vecs[v].len);
            check("frame_bits_fn",
                  frame_bits(vecs[v].sel5 ? 5 : 8, vecs[v].par_en, vecs[v].stop2), vecs[v].len);
            accept(vecs[v].sel5, vecs[v].en_acc, 1'b0);
            run_frame(vecs[v].sel5, vecs[v].len);
            if (vecs[v].sel5) exp_done5++;
            else              exp_done8++;
            tick();
            check("done_one_cycle", s_done(vecs[v].sel5), 1'b0);
            tick();
        end

        // Back-to-back: second word and new config applied during the first frame
        set_word(1'b0, 9'h055, 1'b0, PAR_EVEN, 1'b0, 1'b0);
        push_model(9'h055, 8, 1'b0, PAR_EVEN, 1'b0, 1'b0);
        accept(1'b0, 1'b0, 1'b1);
        set_word(1'b0, 9'h0AA, 1'b1, PAR_EVEN, 1'b1, 1'b1);
        push_model(9'h0AA, 8, 1'b1, PAR_EVEN, 1'b1, 1'b1);
        run_frame(1'b0, 10);
        exp_done8++;
        tick();
        set_valid(1'b0, 1'b0);
        check("b2b_done_cleared", done8, 1'b0);
        check("b2b_start_bit", ser8, 1'b0);
        check("b2b_busy", busy8, 1'b1);
        run_frame(1'b0, 12);
        exp_done8++;
        tick();
        check("b2b_done_one_cycle", done8, 1'b0);
        tick();

        // Abort: reset during the 4th data bit
        set_word(1'b0, 9'h000, 1'b0, PAR_EVEN, 1'b0, 1'b0);
        accept(1'b0, 1'b0, 1'b0);
        check("abort_start_bit", ser8, 1'b0);
        for (int k = 0; k < 4; k++) begin
            repeat (3) tick();
            enable = 1'b1;
            tick();
            enable = 1'b0;
        end
        check("abort_data3_line", ser8, 1'b0);
        check("abort_data3_busy", busy8, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_line_high", ser8, 1'b1);
        check("abort_busy_low", busy8, 1'b0);
        check("abort_ready", if8.Data_Ready, 1'b1);
        check("abort_no_done", done8, 1'b0);
        for (int k = 0; k < 8; k++) begin
            enable = k[0];
            tick();
        end
        enable = 1'b0;
        check("abort_line_stays_high", ser8, 1'b1);
        check("abort_done_count", done_cnt8, exp_done8);

        set_word(1'b0, 9'h03C, 1'b0, PAR_EVEN, 1'b0, 1'b0);
        push_model(9'h03C, 8, 1'b0, PAR_EVEN, 1'b0, 1'b0);
        accept(1'b0, 1'b0, 1'b0);
        run_frame(1'b0, 10);
        exp_done8++;
        tick();
        check("post_abort_done_one_cycle", done8, 1'b0);
        tick();

        check("done_pulses_dw8", done_cnt8, exp_done8);
        check("done_pulses_dw5", done_cnt5, exp_done5);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_serializer.md
# uart_tx_frame_serializer

Parametrised successor to the 8-bit UART transmit serializer. It accepts a parallel word over a valid/ready handshake and emits a complete UART frame: start bit, DATA_W data bits (LSB- or MSB-first), optional even/odd parity, and one or two stop bits. The bit rate is paced by an external one-cycle baud tick, `Enable`. It sits between the TX data source and the line driver and replaces the separate serializer/FSM/parity split with a single framed unit.

## Interface
- DATA_W, 8, data bits per frame; legal range 5..9
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- P_Data  in  DATA_W  parallel word to transmit
- Data_Valid  in  1  P_Data valid
- Data_Ready  out  1  block can accept a word this cycle
- Enable  in  1  one-cycle baud tick; each tick ends the current bit
- Par_En  in  1  1 = insert parity bit
- Par_Typ  in  1  0 = even parity, 1 = odd parity
- Stop2  in  1  1 = two stop bits, 0 = one stop bit
- Msb_First  in  1  1 = MSB first, 0 = LSB first
- Serial_Data  out  1  TX line; idles high
- Busy  out  1  frame in progress
- Done  out  1  one-cycle pulse when the last stop bit completes

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- Accept: fires when `Data_Valid && Data_Ready`. `Data_Ready` = (state == IDLE).
  - On accept, latch P_Data, Par_En, Par_Typ, Stop2 and Msb_First into a config/shift register, then go to START.
  - Config input changes mid-frame have no effect.
- Transitions (each transition out of a non-IDLE state happens only on a cycle with `Enable`=1):
  - START → DATA
  - DATA → DATA until DATA_W bits are sent (bit counter, width $clog2(DATA_W+1)), then → PARITY if Par_En, else → STOP1
  - PARITY → STOP1
  - STOP1 → STOP2 if Stop2, else → IDLE
  - STOP2 → IDLE
- Serial_Data per state:
  - IDLE: 1
  - START: 0
  - DATA: current bit of the shift register. For LSB-first, shift right and output bit 0. For MSB-first, shift left and output bit DATA_W-1.
  - PARITY: XOR of the latched word, inverted when Par_Typ=1
  - STOP1/STOP2: 1
- Serial_Data is registered (glitch-free); it is driven from state and shift-register flops.
- Busy = (state != IDLE).
- Done is registered and high for exactly one cycle: the cycle after the Enable that leaves the final stop state.
- Frame length in Enable ticks: 1 + DATA_W + Par_En + 1 + Stop2.

## Timing
- Reset values: state IDLE, Serial_Data=1, Busy=0, Data_Ready=1, Done=0, shift register 0, bit counter 0.
- Reset takes effect on the next CLK edge and overrides any event in that cycle. Reset mid-frame aborts the frame, and the line returns high on the next cycle with no Done pulse.
- Accept at edge t: Serial_Data=0 and Busy=1 from edge t+1.
- An Enable coincident with the accept cycle is ignored and does not shorten or skip the start bit.
- The bit boundary is the edge at which Enable=1 is sampled. The new bit value appears after that edge.
- Last stop bit ends at edge e: state IDLE, Done=1 and Data_Ready=1 from e+1. The earliest next accept is at edge e+1, so back-to-back frames have zero idle cycles beyond the stop bit(s).
- Enable pulses while in IDLE are ignored.
- Data_Valid held while Busy: the word is not consumed and must be held until Data_Ready.

## Structure
- Package `uart_tx_pkg`:
  - state enum `tx_state_e`
  - parity constants PAR_EVEN=0 and PAR_ODD=1
  - function `frame_bits(data_w, par_en, stop2)` for the bench
- One sub-module, `uart_tx_shift_reg`. It is parametrised by DATA_W and provides load, shift-on-enable, direction select, current-bit output and parity output. The FSM, counter and handshake live in the top.

## Test plan
- **Reset and idle:** assert RST for 2 cycles, then release; pulse Enable ×5 with no valid → Serial_Data=1, Busy=0, Data_Ready=1, Done never asserted.
- **LSB-first 8N1:** P_Data=8'hA5, Par_En=0, Stop2=0, Enable every 4 cycles → line 0,1,0,1,0,0,1,0,1,1 (10 ticks), then Done pulses once.
- **Parity:**
  - P_Data=8'h07 with even parity → parity bit 1.
  - Same word with odd parity → parity bit 0.
  - Frame is 11 ticks in both cases.
- **MSB-first, 2 stop bits, DATA_W=5:** P_Data=5'b10011 → line 0,1,0,0,1,1,1,1 (8 ticks).
- **Back-to-back:** Data_Valid held high with 8'h55 then 8'hAA → second start bit begins the cycle after Done; no extra idle bit; config changes made mid-frame are ignored.
- **Abort:** RST asserted during the 4th data bit → Serial_Data=1 and Busy=0 next cycle, no Done; a new frame (8'h3C) is then sent correctly.
